// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stall, flush, forwarding, memory-wait freeze.
// FORWARD_EN: forwarding + load-use detection; undefined: pending-write scoreboard, no forwarding.
module pipeline_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  RS1_D,
  input  logic [RA_W-1:0]  RS2_D,
  input  logic [RA_W-1:0]  RD_D,
  input  logic             RegWriteD,
  input  logic [RA_W-1:0]  RS1_E,
  input  logic [RA_W-1:0]  RS2_E,
  input  logic [RA_W-1:0]  RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [RA_W-1:0]  RD_M,
  input  logic [RA_W-1:0]  RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallB,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {RUN, MEMWAIT} state_t;
  state_t state;

  logic mem_stall, hazard_hit, hazard;

  // The first not-ready cycle stalls combinationally; the ready cycle already releases.
  assign mem_stall = ~MemReady & (MemReqM | (state == MEMWAIT));
  assign hazard    = hazard_hit & ~mem_stall & ~PCSrcE;

  assign StallF = rst & (mem_stall | hazard);
  assign StallD = rst & (mem_stall | hazard);
  assign StallB = rst & mem_stall;
  assign FlushD = rst & ~mem_stall & PCSrcE;
  assign FlushE = rst & ~mem_stall & (PCSrcE | hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (MemReqM && !MemReady) state <= MEMWAIT;
        MEMWAIT: if (MemReady) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      StallCount <= '0;
    else if (StallD && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end

`ifdef FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (RegWriteM && (RD_M != '0) && (RD_M == rs))      return 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == rs)) return 2'b01;
    else                                                return 2'b00;
  endfunction

  assign hazard_hit = RegWriteE & ResultSrcE & (RD_E != '0) &
                      ((RD_E == RS1_D) | (RD_E == RS2_D));
  assign ForwardAE  = rst ? fwd_sel(RS1_E) : 2'b00;
  assign ForwardBE  = rst ? fwd_sel(RS2_E) : 2'b00;

  logic unused_cfg;
  assign unused_cfg = ^{RegWriteD, RD_D};
`else
  logic [2**RA_W-1:0] pending;
  logic               issue;

  assign issue = RegWriteD & (RD_D != '0) & ~StallD & ~StallB & ~FlushE;

  // Clear first so a same-index set on the same edge wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (RegWriteW) pending[RD_W] <= 1'b0;
      if (issue)     pending[RD_D] <= 1'b1;
    end
  end

  assign hazard_hit = pending[RS1_D] | pending[RS2_D];
  assign ForwardAE  = 2'b00;
  assign ForwardBE  = 2'b00;

  logic unused_cfg;
  assign unused_cfg = ^{RS1_E, RS2_E, RD_E, RegWriteE, ResultSrcE, RD_M, RegWriteM};
`endif

endmodule
